// File: rtl/macc_pkg.sv
// Shared types and arithmetic helpers for the pipelined signed multiply-accumulate unit.
// Helpers work on a fixed wide signed type so one definition serves every accumulator width.
package macc_pkg;

  localparam int MAXW = 128;

  typedef logic signed [MAXW-1:0] wide_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic sub;
  } stage_t;

  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } add_t;

  // Largest value representable in a w-bit two's complement accumulator.
  function automatic wide_t acc_max(input int w);
    wide_t r;
    r = '1;
    r = r >> (MAXW - w + 1);
    return r;
  endfunction

  function automatic wide_t acc_min(input int w);
    return ~acc_max(w);
  endfunction

  // Add at full width; the flag reports whether the sum leaves the w-bit range.
  function automatic add_t sat_add(input wide_t x, input wide_t y, input int w);
    add_t  r;
    wide_t s;
    s     = x + y;
    r.sum = s;
    r.ovf = (s > acc_max(w)) || (s < acc_min(w));
    return r;
  endfunction

endpackage

// File: rtl/macc_sat_add.sv
// Accumulator update: SIZEOUT+1 wide add with overflow detection and
// clamp-or-wrap result selection.
module macc_sat_add
  import macc_pkg::*;
#(
  parameter int SIZEOUT  = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [SIZEOUT-1:0] acc_i,
  input  logic                      clr_i,
  input  logic signed [SIZEOUT:0]   p_i,
  output logic signed [SIZEOUT-1:0] res_o,
  output logic                      ovf_o
);

  generate
    if (SIZEOUT + 1 > MAXW) begin : g_too_wide
      $error("macc_sat_add: SIZEOUT exceeds helper width");
    end
  endgenerate

  wide_t acc_w;
  wide_t p_w;
  wide_t clamp_w;
  wide_t sum_w;
  add_t  r;

  always_comb begin
    acc_w   = clr_i ? '0 : {{(MAXW-SIZEOUT){acc_i[SIZEOUT-1]}}, acc_i};
    p_w     = {{(MAXW-SIZEOUT-1){p_i[SIZEOUT]}}, p_i};
    r       = sat_add(acc_w, p_w, SIZEOUT);
    sum_w   = r.sum;
    ovf_o   = r.ovf;
    // An overflowing sum is never zero, so its sign alone picks the rail.
    clamp_w = sum_w[MAXW-1] ? acc_min(SIZEOUT) : acc_max(SIZEOUT);
    if (r.ovf && SATURATE) begin
      res_o = clamp_w[SIZEOUT-1:0];
    end else begin
      res_o = sum_w[SIZEOUT-1:0];
    end
  end

endmodule

// File: rtl/macc_pipe.sv
// Fully pipelined signed multiply-accumulate: A/B register, M register, P register,
// with per-sample subtract, in-band load, sticky overflow and a saturating run counter.
module macc_pipe
  import macc_pkg::*;
#(
  parameter int SIZEIN   = 16,
  parameter int SIZEOUT  = 40,
  parameter bit SATURATE = 1'b1,
  parameter int CNTW     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic                      first,
  input  logic                      sub,
  input  logic signed [SIZEIN-1:0]  a,
  input  logic signed [SIZEIN-1:0]  b,
  output logic                      out_valid,
  output logic signed [SIZEOUT-1:0] accum_out,
  output logic                      overflow,
  output logic [CNTW-1:0]           count
);

  generate
    if (SIZEOUT < 2*SIZEIN + 1) begin : g_bad_width
      $error("macc_pipe: SIZEOUT must be at least 2*SIZEIN+1");
    end
  endgenerate

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // Stage 1: operand and control capture
  logic signed [SIZEIN-1:0]  a_q, a_d;
  logic signed [SIZEIN-1:0]  b_q, b_d;
  stage_t                    s1_q, s1_d;

  // Stage 2: signed product, already negated for subtract
  logic signed [SIZEOUT:0]   p_q, p_d;
  stage_t                    s2_q, s2_d;

  // Stage 3: accumulator and run status
  logic signed [SIZEOUT-1:0] acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic                      ovld_q, ovld_d;

  logic signed [2*SIZEIN-1:0] a_ext;
  logic signed [2*SIZEIN-1:0] b_ext;
  logic signed [2*SIZEIN-1:0] prod;
  logic signed [SIZEOUT:0]    p_ext;
  logic signed [SIZEOUT-1:0]  sum_res;
  logic                       sum_ovf;

  macc_sat_add #(
    .SIZEOUT  (SIZEOUT),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc_i (acc_q),
    .clr_i (s2_q.first),
    .p_i   (p_q),
    .res_o (sum_res),
    .ovf_o (sum_ovf)
  );

  always_comb begin
    a_d  = a;
    b_d  = b;
    s1_d = '{valid: in_valid, first: first, sub: sub};

    a_ext = {{SIZEIN{a_q[SIZEIN-1]}}, a_q};
    b_ext = {{SIZEIN{b_q[SIZEIN-1]}}, b_q};
    prod  = a_ext * b_ext;
    p_ext = {{(SIZEOUT+1-2*SIZEIN){prod[2*SIZEIN-1]}}, prod};
    p_d   = s1_q.sub ? -p_ext : p_ext;
    s2_d  = s1_q;

    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    ovld_d = s2_q.valid;
    if (s2_q.valid) begin
      acc_d = sum_res;
      // A load starts a new run, so it discards the previous sticky flag.
      ovf_d = (!s2_q.first && ovf_q) || sum_ovf;
      if (s2_q.first) begin
        cnt_d = CNT_ONE;
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s1_q   <= '0;
      p_q    <= '0;
      s2_q   <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      ovld_q <= 1'b0;
    end else if (ce) begin
      a_q    <= a_d;
      b_q    <= b_d;
      s1_q   <= s1_d;
      p_q    <= p_d;
      s2_q   <= s2_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      ovld_q <= ovld_d;
    end
  end

  assign out_valid = ovld_q;
  assign accum_out = acc_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_macc_pipe.sv
// Directed bench for macc_pipe: four instances (default, 33-bit saturating,
// 33-bit wrapping, 2-bit counter) share one stimulus stream.
module tb_macc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ce, in_valid, first, sub;
  logic signed [15:0] a, b;

  logic               d_ov, d_ovf;
  logic signed [39:0] d_acc;
  logic [15:0]        d_cnt;
  logic               s_ov, s_ovf;
  logic signed [32:0] s_acc;
  logic [15:0]        s_cnt;
  logic               w_ov, w_ovf;
  logic signed [32:0] w_acc;
  logic [15:0]        w_cnt;
  logic               c_ov, c_ovf;
  logic signed [39:0] c_acc;
  logic [1:0]         c_cnt;

  macc_pipe u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .a(a), .b(b), .out_valid(d_ov), .accum_out(d_acc), .overflow(d_ovf), .count(d_cnt));

  macc_pipe #(.SIZEIN(16), .SIZEOUT(33), .SATURATE(1'b1), .CNTW(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .a(a), .b(b), .out_valid(s_ov), .accum_out(s_acc), .overflow(s_ovf), .count(s_cnt));

  macc_pipe #(.SIZEIN(16), .SIZEOUT(33), .SATURATE(1'b0), .CNTW(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .a(a), .b(b), .out_valid(w_ov), .accum_out(w_acc), .overflow(w_ovf), .count(w_cnt));

  macc_pipe #(.SIZEIN(16), .SIZEOUT(40), .SATURATE(1'b1), .CNTW(2)) u_cnt (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .a(a), .b(b), .out_valid(c_ov), .accum_out(c_acc), .overflow(c_ovf), .count(c_cnt));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic f, input logic s,
                     input logic signed [15:0] ta, input logic signed [15:0] tb);
    in_valid = v;
    first    = f;
    sub      = s;
    a        = ta;
    b        = tb;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " def acc"}, 64'(d_acc), 64'sd0);
    chk({tag, " def ovf"}, 64'(d_ovf), 64'sd0);
    chk({tag, " def cnt"}, 64'(d_cnt), 64'sd0);
    chk({tag, " def ov"},  64'(d_ov),  64'sd0);
    chk({tag, " sat acc"}, 64'(s_acc), 64'sd0);
    chk({tag, " cnt cnt"}, 64'(c_cnt), 64'sd0);
  endtask

  typedef struct {
    logic               v, f, s;
    logic signed [15:0] a, b;
    logic               exp_ov;
    longint             exp_acc;
    logic               exp_ovf;
    int                 exp_cnt;
  } vec_t;

  localparam int NTBL = 8;
  vec_t tbl [NTBL];

  localparam int NSEQ = 8;
  logic signed [15:0] seq_a   [NSEQ];
  logic signed [15:0] seq_b   [NSEQ];
  logic               seq_f   [NSEQ];
  longint             sat_exp [NSEQ];
  longint             wrap_exp[NSEQ];
  logic               ovf_exp [NSEQ];
  int                 cnt2_exp[NSEQ];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0,  16'sd3,     16'sd4,     1'b1,  64'sd12,         1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b0,  16'sd5,    -16'sd6,     1'b1, -64'sd18,         1'b0, 2};
    tbl[2] = '{1'b0, 1'b0, 1'b0,  16'sd100,   16'sd100,   1'b0, -64'sd18,         1'b0, 2};
    tbl[3] = '{1'b1, 1'b0, 1'b1,  16'sd2,     16'sd7,     1'b1, -64'sd32,         1'b0, 3};
    tbl[4] = '{1'b1, 1'b0, 1'b0, -16'sd3,    -16'sd3,     1'b1, -64'sd23,         1'b0, 4};
    tbl[5] = '{1'b0, 1'b1, 1'b0,  16'sd9,     16'sd9,     1'b0, -64'sd23,         1'b0, 4};
    tbl[6] = '{1'b1, 1'b1, 1'b1, -16'sd32768, 16'sd32767, 1'b1,  64'sd1073709056, 1'b0, 1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, -16'sd32768,-16'sd32768, 1'b1,  64'sd2147450880, 1'b0, 2};

    for (int i = 0; i < NSEQ; i++) begin
      seq_a[i] = 16'sd32767;
      seq_b[i] = 16'sd32767;
      seq_f[i] = (i == 0);
    end
    seq_a[6] = -16'sd32767;
    seq_a[7] = 16'sd1;
    seq_b[7] = 16'sd1;
    seq_f[7] = 1'b1;
    sat_exp  = '{64'sd1073676289, 64'sd2147352578, 64'sd3221028867, 64'sd4294705156,
                 64'sd4294967295, 64'sd4294967295, 64'sd3221291006, 64'sd1};
    wrap_exp = '{64'sd1073676289, 64'sd2147352578, 64'sd3221028867, 64'sd4294705156,
                 -64'sd3221553147, -64'sd2147876858, -64'sd3221553147, 64'sd1};
    ovf_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    cnt2_exp = '{1, 2, 3, 3, 3, 3, 3, 1};

    // Reset state
    ce    = 1'b1;
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Table: one sample per enabled edge, result checked three edges later
    for (int i = 0; i < NTBL + 2; i++) begin
      if (i < NTBL) drv(tbl[i].v, tbl[i].f, tbl[i].s, tbl[i].a, tbl[i].b);
      else          drv(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
      step();
      if (i >= 2) begin
        chk($sformatf("tbl[%0d] ov",  i-2), 64'(d_ov),  64'(tbl[i-2].exp_ov));
        chk($sformatf("tbl[%0d] acc", i-2), 64'(d_acc), tbl[i-2].exp_acc);
        chk($sformatf("tbl[%0d] ovf", i-2), 64'(d_ovf), 64'(tbl[i-2].exp_ovf));
        chk($sformatf("tbl[%0d] cnt", i-2), 64'(d_cnt), 64'(tbl[i-2].exp_cnt));
      end
    end

    // Subtract-load followed by a four-cycle stall
    drv(1'b1, 1'b1, 1'b1, -16'sd32768, 16'sd32767);
    step();
    ce = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 16'sd1000, 16'sd1000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stall%0d acc", i), 64'(d_acc), 64'sd2147450880);
      chk($sformatf("stall%0d ov",  i), 64'(d_ov),  64'sd0);
      chk($sformatf("stall%0d cnt", i), 64'(d_cnt), 64'sd2);
    end
    ce = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    step();
    chk("stall k+1 acc", 64'(d_acc), 64'sd2147450880);
    chk("stall k+1 ov",  64'(d_ov),  64'sd0);
    step();
    chk("stall k+2 acc", 64'(d_acc), 64'sd1073709056);
    chk("stall k+2 ov",  64'(d_ov),  64'sd1);
    chk("stall k+2 cnt", 64'(d_cnt), 64'sd1);
    chk("stall k+2 ovf", 64'(d_ovf), 64'sd0);
    ce = 1'b0;
    step();
    step();
    chk("hold ov", 64'(d_ov), 64'sd1);
    chk("hold acc", 64'(d_acc), 64'sd1073709056);
    ce = 1'b1;
    step();
    chk("pulse end ov", 64'(d_ov), 64'sd0);

    // Saturate / wrap / 2-bit counter run
    for (int i = 0; i < NSEQ + 2; i++) begin
      if (i < NSEQ) drv(1'b1, seq_f[i], 1'b0, seq_a[i], seq_b[i]);
      else          drv(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
      step();
      if (i >= 2) begin
        chk($sformatf("seq[%0d] sat acc",  i-2), 64'(s_acc), sat_exp[i-2]);
        chk($sformatf("seq[%0d] sat ovf",  i-2), 64'(s_ovf), 64'(ovf_exp[i-2]));
        chk($sformatf("seq[%0d] wrap acc", i-2), 64'(w_acc), wrap_exp[i-2]);
        chk($sformatf("seq[%0d] wrap ovf", i-2), 64'(w_ovf), 64'(ovf_exp[i-2]));
        chk($sformatf("seq[%0d] cnt2",     i-2), 64'(c_cnt), 64'(cnt2_exp[i-2]));
        chk($sformatf("seq[%0d] sat cnt",  i-2), 64'(s_cnt), 64'((i-2 == 7) ? 1 : i-1));
      end
    end

    // Asynchronous reset between edges with a sample still in flight
    drv(1'b1, 1'b1, 1'b0, 16'sd7, 16'sd7);
    step();
    drv(1'b1, 1'b0, 1'b0, 16'sd2, 16'sd3);
    step();
    drv(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    step();
    chk("pre-reset acc", 64'(d_acc), 64'sd49);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-rst%0d ov",  i), 64'(d_ov),  64'sd0);
      chk($sformatf("post-rst%0d acc", i), 64'(d_acc), 64'sd0);
      chk($sformatf("post-rst%0d cnt", i), 64'(d_cnt), 64'sd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
